// File: rtl/mux_rrb.sv
// Registered N:1 arbiter/mux: picks one requesting channel per cycle (fixed priority
// or round-robin), captures its data and one-hot grant in an output register.
module mux_rrb #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 16,
  parameter int  MODE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] req_vld,
  output logic [WIDTH-1:0] req_rdy,
  input  DAT_T [WIDTH-1:0] ary,
  output logic             vld,
  input  logic             rdy,
  output DAT_T             dat,
  output logic [WIDTH-1:0] oht
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             load_s;
  logic             any_s;
  logic [IW-1:0]    idx_s;
  logic [WIDTH-1:0] gnt_s;
  logic [IW-1:0]    ptr_s;
  logic             xfer_s;

  logic             vld_r;
  DAT_T             dat_r;
  logic [WIDTH-1:0] oht_r;

  // First set index of v scanning upward from start, wrapping past WIDTH-1.
  function automatic logic [IW-1:0] pick_idx(input logic [WIDTH-1:0] v,
                                             input logic [IW-1:0]    start);
    logic [IW-1:0] r;
    logic [IW-1:0] j;
    logic [IW:0]   s;
    logic          hit;
    r   = '0;
    hit = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      s = {1'b0, start} + (IW+1)'(k);
      if (s >= (IW+1)'(WIDTH)) begin
        s = s - (IW+1)'(WIDTH);
      end else begin
        s = s;
      end
      j = s[IW-1:0];
      if (!hit && v[j]) begin
        hit = 1'b1;
        r   = j;
      end else begin
        hit = hit;
      end
    end
    return r;
  endfunction

  // Grant selection and upstream handshake.
  always_comb begin
    load_s  = ~vld_r | rdy;
    any_s   = |req_vld;
    idx_s   = pick_idx(req_vld, ptr_s);
    gnt_s   = '0;
    req_rdy = '0;
    if (any_s) begin
      gnt_s = WIDTH'(1'b1) << idx_s;
    end else begin
      gnt_s = '0;
    end
    if (load_s && rst_n) begin
      req_rdy = gnt_s;
    end else begin
      req_rdy = '0;
    end
    xfer_s = |(req_vld & req_rdy);
  end

  // Output register: load a new item, drain to empty, or hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_r <= 1'b0;
      dat_r <= '0;
      oht_r <= '0;
    end else if (load_s) begin
      if (any_s) begin
        vld_r <= 1'b1;
        dat_r <= ary[idx_s];
        oht_r <= gnt_s;
      end else begin
        vld_r <= 1'b0;
      end
    end
  end

  generate
    if (MODE == 1) begin : g_rr
      logic [IW-1:0] ptr_r;
      logic [IW-1:0] ptr_nxt_s;

      // Pointer advances to the slot just past the winner so it gets lowest priority next.
      always_comb begin
        if (idx_s == IW'(WIDTH - 1)) begin
          ptr_nxt_s = '0;
        end else begin
          ptr_nxt_s = idx_s + IW'(1);
        end
      end

      // Round-robin pointer register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ptr_r <= '0;
        end else if (xfer_s) begin
          ptr_r <= ptr_nxt_s;
        end
      end

      assign ptr_s = ptr_r;
    end else begin : g_fixed
      assign ptr_s = '0;
    end
  endgenerate

  assign vld = vld_r;
  assign dat = dat_r;
  assign oht = oht_r;

endmodule

// File: doc/mux_rrb.md
MUX_RRB -- requirements
Module: mux_rrb

Interface
REQ-001 SHALL have parameter DAT_T, default logic [8-1:0], the data element type.
REQ-002 SHALL have parameter WIDTH, default 16, the number of input channels; the legal range is WIDTH >= 1.
REQ-003 SHALL have parameter MODE, default 1; 0 selects fixed priority (lowest index wins), 1 selects round-robin.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-006 SHALL have port req_vld, input, WIDTH bits, the per-channel request valid.
REQ-007 SHALL have port req_rdy, output, WIDTH bits, the per-channel accept; at most one bit is set.
REQ-008 SHALL have port ary, input, DAT_T [WIDTH-1:0], the per-channel data.
REQ-009 SHALL have port vld, output, 1 bit, the registered output valid.
REQ-010 SHALL have port rdy, input, 1 bit, the downstream ready.
REQ-011 SHALL have port dat, output, DAT_T, the registered selected data.
REQ-012 SHALL have port oht, output, WIDTH bits, the registered one-hot grant that produced dat.

Function
REQ-013 SHALL compute load = ~vld | rdy; the output register accepts a new item only when load=1.
REQ-014 SHALL compute grant gnt combinationally as a one-hot vector over req_vld; gnt SHALL be all zero when req_vld is zero.
REQ-015 MODE=0: gnt SHALL select the lowest set index of req_vld.
REQ-016 MODE=1: gnt SHALL select the first set index at or above pointer ptr, wrapping from WIDTH-1 to 0.
REQ-017 SHALL drive req_rdy = gnt when load=1 and rst_n=1, else all zero; a transfer on channel i occurs when req_vld[i] & req_rdy[i].
REQ-018 On a clock edge with load=1 and gnt nonzero: vld<=1, dat<=ary[index of gnt], oht<=gnt.
REQ-019 On a clock edge with load=1 and gnt zero: vld<=0; dat and oht SHALL hold their values.
REQ-020 On a clock edge with load=0 (vld=1, rdy=0): vld, dat and oht SHALL hold, and no input transfer SHALL occur.
REQ-021 MODE=1: ptr SHALL be log2-sized (minimum 1 bit), and on each input transfer ptr <= (granted index + 1) mod WIDTH; otherwise ptr SHALL hold.
REQ-022 MODE=0: ptr SHALL be unused and constant 0.
REQ-023 Latency from input transfer to vld=1 SHALL be exactly 1 cycle; sustained throughput SHALL be 1 item per cycle when rdy=1.
REQ-024 A simultaneous output transfer (vld&rdy) and input transfer in the same cycle SHALL replace the register contents with no bubble.
REQ-025 WIDTH=1: gnt = req_vld; the block SHALL behave as a 1-stage pipeline register.
REQ-026 Upstream channels SHALL hold req_vld and ary stable until accepted; the block SHALL NOT check this.

Reset
REQ-027 When rst_n=0 at a rising edge: vld<=0, dat<=0, oht<=0, ptr<=0.
REQ-028 While rst_n=0, req_rdy SHALL be all zero regardless of req_vld and rdy.
REQ-029 Reset asserted mid-stream SHALL discard the registered item; no input transfer SHALL occur in any cycle with rst_n=0.

Verification (WIDTH=4, ary[i]=i unless stated)
REQ-030 Reset: rst_n=0, req_vld=4'b1111, rdy=1 for 2 cycles -> vld=0, dat=0, oht=0, req_rdy=0 throughout; after release the first grant is index 0.
REQ-031 Single request: req_vld=4'b0100, rdy=1 -> req_rdy=4'b0100 in the same cycle; the next cycle has vld=1, dat=2, oht=4'b0100.
REQ-032 Fairness: req_vld=4'b1111 held, rdy=1 -> MODE=1 yields dat sequence 0,1,2,3,0,1; MODE=0 yields dat=0 every cycle.
REQ-033 Backpressure: with vld=1 and dat=1, rdy=0 for 3 cycles -> dat=1, oht=4'b0010 and req_rdy=0 hold; rdy=1 then produces the next grant 1 cycle later.
REQ-034 Wrap and skip (MODE=1): after a grant to index 2, req_vld=4'b0011 -> grant index 0 (dat=0), then index 1.
REQ-035 Idle drain: vld=1, rdy=1, req_vld=0 -> the next cycle has vld=0, and dat and oht unchanged.
